// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage access unit: widths, opcodes,
// exception causes, FSM states and opcode classification helpers.
package mem_access_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int RADDR_WIDTH = 5;
    localparam int RDATA_WIDTH = 32;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return lo[0];
            MEM_LW, MEM_SW:          return lo != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatting: store select/replication and load
// extract with sign or zero extension.
module mem_lane_fmt
    import mem_access_pkg::*;
(
    input  logic [3:0]             op_i,
    input  logic [1:0]             addr_lo_i,
    input  logic [DATA_WIDTH-1:0]  st_data_i,
    input  logic [DATA_WIDTH-1:0]  ld_data_i,
    output logic [3:0]             sel_o,
    output logic [DATA_WIDTH-1:0]  wdata_o,
    output logic [RDATA_WIDTH-1:0] ld_result_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [3:0]  byte_sel;
    logic [3:0]  half_sel;

    always_comb begin
        byte_v = ld_data_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_v = ld_data_i[7:0];
            2'd1:    byte_v = ld_data_i[15:8];
            2'd2:    byte_v = ld_data_i[23:16];
            default: byte_v = ld_data_i[31:24];
        endcase
        half_v   = addr_lo_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
        byte_sel = 4'b0001 << addr_lo_i;
        half_sel = addr_lo_i[1] ? 4'b1100 : 4'b0011;

        sel_o       = '0;
        wdata_o     = '0;
        ld_result_o = '0;
        case (op_i)
            MEM_LB: begin
                sel_o       = byte_sel;
                ld_result_o = {{24{byte_v[7]}}, byte_v};
            end
            MEM_LBU: begin
                sel_o       = byte_sel;
                ld_result_o = {24'd0, byte_v};
            end
            MEM_LH: begin
                sel_o       = half_sel;
                ld_result_o = {{16{half_v[15]}}, half_v};
            end
            MEM_LHU: begin
                sel_o       = half_sel;
                ld_result_o = {16'd0, half_v};
            end
            MEM_LW: begin
                sel_o       = 4'b1111;
                ld_result_o = ld_data_i;
            end
            MEM_SB: begin
                sel_o   = byte_sel;
                wdata_o = {4{st_data_i[7:0]}};
            end
            MEM_SH: begin
                sel_o   = half_sel;
                wdata_o = {2{st_data_i[15:0]}};
            end
            MEM_SW: begin
                sel_o   = 4'b1111;
                wdata_o = st_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage access unit: runs one load/store at a time on a req/ack bus,
// stalls the pipeline meanwhile, and formats write-back data and exceptions.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    input  logic [3:0]             mem_op_i,
    input  logic                   flush_int_i,
    output logic                   bus_req_o,
    output logic                   bus_we_o,
    output logic [ADDR_WIDTH-1:0]  bus_addr_o,
    output logic [DATA_WIDTH-1:0]  bus_wdata_o,
    output logic [3:0]             bus_sel_o,
    input  logic [DATA_WIDTH-1:0]  bus_rdata_i,
    input  logic                   bus_ack_i,
    input  logic                   bus_err_i,
    output logic                   stall_req_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [RDATA_WIDTH-1:0] reg_wdata_o,
    output logic                   exc_valid_o,
    output logic [3:0]             exc_cause_o,
    output logic [ADDR_WIDTH-1:0]  exc_tval_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   flush_q, flush_d;
    logic                   fault_q, fault_d;
    logic                   we_q, we_d;
    logic [3:0]             op_q, op_d;
    logic [3:0]             sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [RDATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                   issue;
    logic                   misaligned;
    logic                   kill;
    logic [3:0]             fmt_op;
    logic [1:0]             fmt_lo;
    logic [3:0]             fmt_sel;
    logic [DATA_WIDTH-1:0]  fmt_wdata;
    logic [RDATA_WIDTH-1:0] fmt_ld;

    // One formatter serves both phases: live inputs build the store lanes at
    // issue, the latched op/address extract the load data on ack.
    assign fmt_op = (state_q == ST_IDLE) ? mem_op_i : op_q;
    assign fmt_lo = (state_q == ST_IDLE) ? mem_addr_i[1:0] : addr_q[1:0];

    mem_lane_fmt u_lane_fmt (
        .op_i        (fmt_op),
        .addr_lo_i   (fmt_lo),
        .st_data_i   (mem_data_i),
        .ld_data_i   (bus_rdata_i),
        .sel_o       (fmt_sel),
        .wdata_o     (fmt_wdata),
        .ld_result_o (fmt_ld)
    );

    assign issue      = (is_load(mem_op_i) || is_store(mem_op_i)) && !flush_int_i;
    assign misaligned = is_misaligned(mem_op_i, mem_addr_i[1:0]);
    assign kill       = flush_q || flush_int_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        fault_d = fault_q;
        we_d    = we_q;
        op_d    = op_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        bus_sel_o   = '0;
        stall_req_o = 1'b0;
        reg_waddr_o = reg_waddr_i;
        reg_we_o    = 1'b0;
        reg_wdata_o = '0;
        exc_valid_o = 1'b0;
        exc_cause_o = '0;
        exc_tval_o  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (!issue) begin
                    reg_we_o    = reg_we_i;
                    reg_wdata_o = reg_wdata_i;
                end else if (misaligned) begin
                    exc_valid_o = 1'b1;
                    exc_cause_o = is_load(mem_op_i) ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
                    exc_tval_o  = mem_addr_i;
                end else begin
                    stall_req_o = 1'b1;
                    state_d     = ST_REQ;
                    cnt_d       = '0;
                    flush_d     = 1'b0;
                    fault_d     = 1'b0;
                    op_d        = mem_op_i;
                    addr_d      = mem_addr_i;
                    we_d        = is_store(mem_op_i);
                    sel_d       = fmt_sel;
                    wdata_d     = fmt_wdata;
                end
            end
            ST_REQ: begin
                bus_req_o   = 1'b1;
                stall_req_o = 1'b1;
                bus_we_o    = we_q;
                bus_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                bus_wdata_o = wdata_q;
                bus_sel_o   = sel_q;
                cnt_d       = cnt_q + 8'd1;
                if (flush_int_i) flush_d = 1'b1;
                if (bus_err_i) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else if (bus_ack_i) begin
                    rdata_d = fmt_ld;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                flush_d     = 1'b0;
                fault_d     = 1'b0;
                reg_wdata_o = is_load(op_q) ? rdata_q : reg_wdata_i;
                reg_we_o    = is_load(op_q) && reg_we_i && !fault_q && !kill;
                if (fault_q && !kill) begin
                    exc_valid_o = 1'b1;
                    exc_cause_o = is_load(op_q) ? EXC_LOAD_FAULT : EXC_STORE_FAULT;
                    exc_tval_o  = addr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst_i) begin
            bus_req_o   = 1'b0;
            bus_we_o    = 1'b0;
            bus_addr_o  = '0;
            bus_wdata_o = '0;
            bus_sel_o   = '0;
            stall_req_o = 1'b0;
            reg_waddr_o = '0;
            reg_we_o    = 1'b0;
            reg_wdata_o = '0;
            exc_valid_o = 1'b0;
            exc_cause_o = '0;
            exc_tval_o  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            fault_q <= 1'b0;
            we_q    <= 1'b0;
            op_q    <= MEM_NOP;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            fault_q <= fault_d;
            we_q    <= we_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
